// File: rtl/morse_char_emitter_pkg.sv
// Shared Morse types, timing constants and the emitter FSM state encoding.
package morse_pkg;

    typedef struct packed {
        logic [2:0] len;
        logic [4:0] pattern;
    } morse_code_t;

    localparam logic [2:0] DOT_UNITS        = 3'd1;
    localparam logic [2:0] DASH_UNITS       = 3'd3;
    localparam logic [2:0] SYM_GAP_UNITS    = 3'd1;
    localparam logic [2:0] CHAR_GAP_UNITS   = 3'd3;
    localparam logic [2:0] WORD_EXTRA_UNITS = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        GAP_SYM,
        GAP_CHAR,
        GAP_WORD
    } state_t;

    function automatic morse_code_t mk_code(input logic [2:0] len, input logic [4:0] pattern);
        morse_code_t c;
        c.len     = len;
        c.pattern = pattern;
        return c;
    endfunction

endpackage

// File: rtl/morse_char_emitter_if.sv
// Character handshake between a producer and the Morse emitter.
interface morse_char_emitter_if;
    logic [7:0] char_i;
    logic       char_valid_i;
    logic       char_ready_o;

    modport master (output char_i, output char_valid_i, input char_ready_o);
    modport slave  (input char_i, input char_valid_i, output char_ready_o);
endinterface

// File: rtl/morse_char_encoder.sv
// Combinational ASCII -> Morse code lookup; pattern bit 0 is sent first, 1 = dash.
module morse_char_encoder
    import morse_pkg::*;
(
    input  logic [7:0]  char_i,
    output morse_code_t code,
    output logic        is_space,
    output logic        is_known
);

    logic [7:0] upper;

    // Fold lowercase onto uppercase, then classify and look up the code.
    always_comb begin
        code     = '0;
        is_space = 1'b0;
        is_known = 1'b0;
        upper    = char_i;
        if (char_i >= 8'h61 && char_i <= 8'h7a) upper = char_i - 8'd32;

        if (upper == 8'h20) begin
            is_space = 1'b1;
            is_known = 1'b1;
        end else if (upper >= 8'h30 && upper <= 8'h39) begin
            // Digits 0-5 start with (5-d) dashes after d dots; 6-9 are the complement shape.
            is_known = 1'b1;
            if (upper[3:0] <= 4'd5) code = mk_code(3'd5, 5'b11111 << upper[3:0]);
            else                    code = mk_code(3'd5, ~(5'b11111 << (upper[3:0] - 4'd5)));
        end else if (upper >= 8'h41 && upper <= 8'h5a) begin
            is_known = 1'b1;
            case (upper)
                8'h41: code = mk_code(3'd2, 5'b00010); // A .-
                8'h42: code = mk_code(3'd4, 5'b00001); // B -...
                8'h43: code = mk_code(3'd4, 5'b00101); // C -.-.
                8'h44: code = mk_code(3'd3, 5'b00001); // D -..
                8'h45: code = mk_code(3'd1, 5'b00000); // E .
                8'h46: code = mk_code(3'd4, 5'b00100); // F ..-.
                8'h47: code = mk_code(3'd3, 5'b00011); // G --.
                8'h48: code = mk_code(3'd4, 5'b00000); // H ....
                8'h49: code = mk_code(3'd2, 5'b00000); // I ..
                8'h4a: code = mk_code(3'd4, 5'b01110); // J .---
                8'h4b: code = mk_code(3'd3, 5'b00101); // K -.-
                8'h4c: code = mk_code(3'd4, 5'b00010); // L .-..
                8'h4d: code = mk_code(3'd2, 5'b00011); // M --
                8'h4e: code = mk_code(3'd2, 5'b00001); // N -.
                8'h4f: code = mk_code(3'd3, 5'b00111); // O ---
                8'h50: code = mk_code(3'd4, 5'b00110); // P .--.
                8'h51: code = mk_code(3'd4, 5'b01011); // Q --.-
                8'h52: code = mk_code(3'd3, 5'b00010); // R .-.
                8'h53: code = mk_code(3'd3, 5'b00000); // S ...
                8'h54: code = mk_code(3'd1, 5'b00001); // T -
                8'h55: code = mk_code(3'd3, 5'b00100); // U ..-
                8'h56: code = mk_code(3'd4, 5'b01000); // V ...-
                8'h57: code = mk_code(3'd3, 5'b00110); // W .--
                8'h58: code = mk_code(3'd4, 5'b01001); // X -..-
                8'h59: code = mk_code(3'd4, 5'b01101); // Y -.--
                default: code = mk_code(3'd4, 5'b00011); // Z --..
            endcase
        end
    end

endmodule

// File: rtl/morse_char_emitter.sv
// Serialises accepted ASCII characters as timed on/off Morse keying.
module morse_char_emitter
    import morse_pkg::*;
#(
    parameter int unsigned DOT_PERIOD_WIDTH = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    morse_char_emitter_if.slave         chr,
    input  logic [DOT_PERIOD_WIDTH-1:0] dot_period_i,
    output logic                        morse_o,
    output logic                        busy_o,
    output logic                        unknown_o
);

    state_t                      state, state_nx;
    morse_code_t                 code_q, enc_code;
    logic                        enc_space, enc_known;
    logic [DOT_PERIOD_WIDTH-1:0] period_q, cyc_q;
    logic [2:0]                  unit_q, idx_q, units;
    logic                        period_end, seg_end, ready, transfer;

    morse_char_encoder u_encoder (
        .char_i   (chr.char_i),
        .code     (enc_code),
        .is_space (enc_space),
        .is_known (enc_known)
    );

    assign period_end       = (cyc_q == period_q - DOT_PERIOD_WIDTH'(1));
    assign seg_end          = period_end && (unit_q == units - 3'd1);
    assign chr.char_ready_o = ready;
    assign busy_o           = (state != IDLE);

    // Length, in units, of the segment the current state is timing.
    always_comb begin
        units = DOT_UNITS;
        case (state)
            MARK:     units = code_q.pattern[idx_q] ? DASH_UNITS : DOT_UNITS;
            GAP_SYM:  units = SYM_GAP_UNITS;
            GAP_CHAR: units = CHAR_GAP_UNITS;
            GAP_WORD: units = WORD_EXTRA_UNITS;
            default:  units = DOT_UNITS;
        endcase
    end

    // Next state and handshake; a transfer in a gap's last cycle overrides the return to IDLE.
    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        case (state)
            IDLE:    ready = 1'b1;
            MARK:    if (seg_end) state_nx = (idx_q == code_q.len - 3'd1) ? GAP_CHAR : GAP_SYM;
            GAP_SYM: if (seg_end) state_nx = MARK;
            GAP_CHAR, GAP_WORD: begin
                if (seg_end) begin
                    ready    = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        transfer = ready && chr.char_valid_i;
        if (transfer) begin
            if (!enc_known)    state_nx = IDLE;
            else if (enc_space) state_nx = GAP_WORD;
            else               state_nx = MARK;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nx;
    end

    // Latched character/period, timing counters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            code_q    <= '0;
            period_q  <= DOT_PERIOD_WIDTH'(1);
            cyc_q     <= '0;
            unit_q    <= '0;
            idx_q     <= '0;
            morse_o   <= 1'b0;
            unknown_o <= 1'b0;
        end else begin
            morse_o   <= (state_nx == MARK);
            unknown_o <= transfer && !enc_known;
            if (transfer) begin
                code_q   <= enc_code;
                period_q <= (dot_period_i == '0) ? DOT_PERIOD_WIDTH'(1) : dot_period_i;
                cyc_q    <= '0;
                unit_q   <= '0;
                idx_q    <= '0;
            end else if (state != IDLE) begin
                if (seg_end) begin
                    cyc_q  <= '0;
                    unit_q <= '0;
                    if (state == MARK) idx_q <= idx_q + 3'd1;
                end else if (period_end) begin
                    cyc_q  <= '0;
                    unit_q <= unit_q + 3'd1;
                end else begin
                    cyc_q <= cyc_q + DOT_PERIOD_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: doc/morse_char_emitter.md
Name: morse_char_emitter

Overview:
Upstream stage of morse_char_receiver. It accepts ASCII characters over a valid/ready handshake and serialises each one as on/off Morse keying on morse_o, timed in units of dot_period_i clock cycles. In the loopback bench, morse_o drives the receiver's morse_i, and the same dot_period_i feeds both blocks.

Parameters:
DOT_PERIOD_WIDTH, 16, width of dot_period_i and of the internal cycle counter.

Ports:
clk_i  in  1  clock, single domain
rst_i  in  1  reset, asynchronous, active-low (0 = reset)
char_i  in  8  ASCII character to emit
char_valid_i  in  1  char_i valid
char_ready_o  out  1  emitter can accept a character this cycle
dot_period_i  in  DOT_PERIOD_WIDTH  dot duration in clock cycles
morse_o  out  1  keyed line (1 = mark)
busy_o  out  1  a character or gap is in progress
unknown_o  out  1  one-cycle pulse: accepted char has no Morse code and is dropped

Behaviour:
- Reset (async assert, sync release): state IDLE; morse_o=0, busy_o=0, unknown_o=0, char_ready_o=1 on the first cycle after release. Reset mid-character aborts immediately: morse_o drops low in the same cycle reset asserts, and nothing is resumed.
- Handshake: a transfer occurs on a rising edge with char_valid_i=1 and char_ready_o=1. char_ready_o=1 only in IDLE and in the final cycle of a GAP_CHAR or GAP_WORD. char_i and dot_period_i are held by the emitter only at transfer.
- Effective period P = latched dot_period_i, with 0 treated as 1. Changes on dot_period_i after transfer have no effect on the character in progress.
- Supported characters: 'A'-'Z', 'a'-'z' (mapped to uppercase), '0'-'9', ' ' (space). Letters and digits use ITU codes, 1 to 5 symbols each.
- Unsupported characters:
  - unknown_o pulses high for the one cycle after transfer.
  - morse_o stays 0.
  - The state stays/returns to IDLE, so char_ready_o=1 in that same cycle.
- Timing units:
  - dot = 1 unit high; dash = 3 units high.
  - Gap between symbols of one character = 1 unit low.
  - Gap after each character = 3 units low.
  - Space = 4 units low, giving a 7-unit word gap after the preceding character's 3-unit gap.
- FSM states: IDLE, MARK, GAP_SYM, GAP_CHAR, GAP_WORD.
  - IDLE -> MARK on a letter or digit transfer.
  - IDLE -> GAP_WORD on a space transfer.
  - MARK -> GAP_SYM if symbols remain, else MARK -> GAP_CHAR.
  - GAP_SYM -> MARK.
  - GAP_CHAR and GAP_WORD -> IDLE, or directly -> MARK/GAP_WORD when a transfer occurs in their final cycle. This back-to-back path keeps the inter-character gap exactly 3*P cycles.
- Latency and outputs:
  - morse_o is registered and rises on the cycle after transfer.
  - Each mark or gap lasts exactly units*P cycles.
  - busy_o=1 in every state except IDLE.
- Counters:
  - Cycle counter: DOT_PERIOD_WIDTH bits, counting 0..P-1.
  - Unit counter: 3 bits, counting 0..units-1.
  - Symbol index: 3 bits.
  - No counter wrap is possible inside these ranges.
- Symbol order: pattern bit 0 is emitted first; 1 = dash.
- Simultaneous reset and transfer: reset wins and the character is lost.

Decomposition:
- Package morse_pkg holds:
  - morse_code_t, a packed struct {logic [2:0] len; logic [4:0] pattern;}.
  - Constants DOT_UNITS=1, DASH_UNITS=3, SYM_GAP_UNITS=1, CHAR_GAP_UNITS=3, WORD_EXTRA_UNITS=4.
  - The FSM state enum.
- Sub-module morse_char_encoder: purely combinational lookup, char_i -> {morse_code_t code, is_space, is_known}. It is shared with the receiver's reference model in the bench.

Test Plan:
- dot_period_i=4, 'E' transferred at cycle 0 -> morse_o=1 in cycles 1-4, 0 in cycles 5-16; char_ready_o=1 in cycle 16; busy_o=0 from cycle 17.
- dot_period_i=2, 'a' -> morse_o: high 2, low 2, high 6, low 6 cycles; unknown_o stays 0.
- dot_period_i=1, "ET" back-to-back with char_valid_i held high -> morse_o 1,0,0,0,1,1,1,0,0,0; the gap between characters is exactly 3 cycles.
- dot_period_i=3, ' ' -> morse_o low for 12 cycles with busy_o=1; ready in the last of those cycles.
- '#' -> unknown_o=1 for exactly one cycle, morse_o=0, char_ready_o=1 in that cycle; then '0' with dot_period_i=0 -> five 3-cycle marks separated by 1-cycle gaps.
- Reset (rst_i=0) asserted during the second cycle of a dash -> morse_o=0 asynchronously; after release, char_ready_o=1 and the FSM is in IDLE.
- Loopback to morse_char_receiver with "SOS 09" -> the receiver reports the same characters, with no unknown_o and no dot_period_error_o.
